// File: rtl/lbp_pkg.sv
// Shared types and constants for the parametrised LBP engine:
// FSM encoding, neighbour bit positions in the LBP code, and border-write modes.
package lbp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } lbp_state_e;

  // Bit position of each neighbour in the LBP code (T=top, B=bottom, L=left, R=right).
  localparam int B_TL = 0;
  localparam int B_T  = 1;
  localparam int B_TR = 2;
  localparam int B_L  = 3;
  localparam int B_R  = 4;
  localparam int B_BL = 5;
  localparam int B_B  = 6;
  localparam int B_BR = 7;

  localparam int BORDER_SKIP = 0;
  localparam int BORDER_ZERO = 1;

endpackage

// File: rtl/lbp_engine_param_line_buffer.sv
// Two chained IMG_W-deep row delay lines advanced once per accepted pixel.
// up1 is the pixel one row above the incoming one, up2 the pixel two rows above.
module lbp_engine_param_line_buffer #(
  parameter int IMG_W = 128,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] up1,
  output logic [DW-1:0] up2
);

  localparam int PW = $clog2(IMG_W);

  logic [DW-1:0] mem1 [IMG_W];
  logic [DW-1:0] mem2 [IMG_W];
  logic [PW-1:0] ptr;

  // The slot about to be overwritten holds the value written exactly IMG_W shifts ago.
  assign up1 = mem1[ptr];
  assign up2 = mem2[ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (shift) begin
      ptr <= (ptr == PW'(IMG_W - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      mem1[ptr] <= din;
      mem2[ptr] <= mem1[ptr];
    end
  end

endmodule

// File: rtl/lbp_engine_param.sv
// Streaming 8-neighbour Local Binary Pattern engine: reads the frame once in raster
// order and writes one LBP code per pixel position (border handling selectable).
module lbp_engine_param
  import lbp_pkg::*;
#(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DW          = 8,
  parameter int AW          = $clog2(IMG_W * IMG_H),
  parameter int THR         = 0,
  parameter int BORDER_MODE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish,
  output lbp_state_e    fsm_state
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(N - 1);
  localparam logic [AW-1:0] FIRST_ISSUE = AW'(IMG_W + 1);
  localparam logic [DW:0]   THR_V       = (DW + 1)'(THR);

  lbp_state_e state, next_state;
  logic [AW-1:0] rd_addr, ctr_addr;
  logic [CW-1:0] ctr_col;
  logic [RW-1:0] ctr_row;
  logic          accept, issue, border, last_ctr;
  logic [DW-1:0] up1, up2;
  logic [DW-1:0] win [3][2];
  logic [DW-1:0] nb  [8];
  logic [DW:0]   ctr_thr;
  logic [7:0]    code;

  // Handshake: a pixel transfers on every cycle where gray_req and gray_ready are both
  // high; gray_data belongs to gray_addr in that cycle and is captured at the next edge.
  assign gray_req  = (state == S_READ);
  assign gray_addr = rd_addr;
  assign accept    = gray_req & gray_ready;
  assign fsm_state = state;

  assign issue    = (accept && (rd_addr >= FIRST_ISSUE)) || (state == S_DRAIN);
  assign border   = (ctr_row == '0) || (ctr_row == RW'(IMG_H - 1)) ||
                    (ctr_col == '0) || (ctr_col == CW'(IMG_W - 1));
  assign last_ctr = (ctr_row == RW'(IMG_H - 1)) && (ctr_col == CW'(IMG_W - 1));

  lbp_engine_param_line_buffer #(.IMG_W(IMG_W), .DW(DW)) u_line_buffer (
    .clk   (clk),
    .reset (reset),
    .shift (accept),
    .din   (gray_data),
    .up1   (up1),
    .up2   (up2)
  );

  // The window seen by the comparators already includes the column arriving this cycle,
  // so the centre is win[1][1] and the right-hand neighbours come straight from the input.
  assign nb[B_TL] = win[0][0];
  assign nb[B_T]  = win[0][1];
  assign nb[B_TR] = up2;
  assign nb[B_L]  = win[1][0];
  assign nb[B_R]  = up1;
  assign nb[B_BL] = win[2][0];
  assign nb[B_B]  = win[2][1];
  assign nb[B_BR] = gray_data;
  assign ctr_thr  = {1'b0, win[1][1]} + THR_V;

  always_comb begin
    code = '0;
    for (int k = 0; k < 8; k++) begin
      code[k] = ({1'b0, nb[k]} >= ctr_thr);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (gray_ready) next_state = S_READ;
      S_READ:  if (accept && (rd_addr == LAST_ADDR)) next_state = S_DRAIN;
      S_DRAIN: if (last_ctr) next_state = S_DONE;
      S_DONE:  next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_addr <= '0;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= '0;
        win[r][1] <= '0;
      end
    end else begin
      state <= next_state;
      if (accept) begin
        if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + 1'b1;
        win[0][0] <= win[0][1];
        win[1][0] <= win[1][1];
        win[2][0] <= win[2][1];
        win[0][1] <= up2;
        win[1][1] <= up1;
        win[2][1] <= gray_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_addr  <= '0;
      ctr_col   <= '0;
      ctr_row   <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else begin
      lbp_valid <= issue && ((BORDER_MODE == BORDER_ZERO) || !border);
      finish    <= (state == S_DONE);
      if (issue) begin
        lbp_addr <= ctr_addr;
        lbp_data <= border ? 8'h00 : code;
        ctr_addr <= ctr_addr + 1'b1;
        if (ctr_col == CW'(IMG_W - 1)) begin
          ctr_col <= '0;
          ctr_row <= ctr_row + 1'b1;
        end else begin
          ctr_col <= ctr_col + 1'b1;
        end
      end
    end
  end

endmodule
